// File: rtl/ddsm_pkg.sv
// Shared DDSM datapath definitions: controller state encoding and counter sizing helper.
package ddsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One extra bit so the pass counter can reach NIB itself without wrapping.
  function automatic int nib_w(input int nib);
    return $clog2(nib) + 1;
  endfunction

endpackage

// File: rtl/adder_serial_seq_lca4.sv
// 4-bit lookahead-carry adder slice; exposes the carry out of every bit position.
module ADDER_LCA_4BIT (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic [3:0] o_cout_bit
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = i_a & i_b;
  assign p = i_a ^ i_b;

  // Each carry is expanded directly from generate/propagate terms rather than rippled.
  assign c[0] = i_cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign o_sum      = p ^ c[3:0];
  assign o_cout_bit = c[4:1];

endmodule

// File: rtl/adder_serial_seq.sv
// Nibble-serial wide adder: one 4-bit slice reused NIB times, carry held in a register between passes.
module adder_serial_seq
  import ddsm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_cout,
  output logic              o_ovf
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = nib_w(NIB);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]        slice_sum;
  logic [3:0]        slice_cout;
  logic [DATA_W-1:0] sum_shift;
  logic              unused_cout_lo;

  ADDER_LCA_4BIT u_slice (
    .i_a        (a_q[3:0]),
    .i_b        (b_q[3:0]),
    .i_cin      (carry_q),
    .o_sum      (slice_sum),
    .o_cout_bit (slice_cout)
  );

  assign unused_cout_lo = ^slice_cout[1:0];

  // New nibble enters at the top so the LSB nibble ends up at the bottom after NIB passes.
  generate
    if (NIB == 1) begin : g_single
      assign sum_shift = slice_sum;
    end else begin : g_multi
      assign sum_shift = {slice_sum, sum_q[DATA_W-1:4]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          carry_d = i_cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = sum_shift;
        carry_d = slice_cout[3];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        cnt_d   = cnt_q + CNT_W'(1);
        // Result flags are only committed on the MSB nibble so they stay stable until the next run.
        if (cnt_q == LAST_CNT) begin
          cout_d  = slice_cout[3];
          ovf_d   = slice_cout[3] ^ slice_cout[2];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule
